// File: rtl/alu_nibble_seq_if.sv
// Command/result handshake bundle for the nibble-serial ALU sequencer.
// master = command source and result consumer, slave = the sequencer.
interface alu_nibble_seq_if #(
  parameter int NIB = 4
);
  localparam int W = 4 * NIB;

  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic [1:0]   cmd_op;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_f;
  logic         res_cout;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
    input  cmd_ready, res_valid, res_f, res_cout
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, res_ready,
    output cmd_ready, res_valid, res_f, res_cout
  );
endinterface

// File: rtl/alu_nibble_seq.sv
// Drives a 4-bit combinational ALU one nibble per clock, LS nibble first, to build
// a W-bit add/add+1/and/or; the inter-nibble carry is recovered from the ALU result.
module alu_nibble_seq #(
  parameter int NIB = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_nibble_seq_if.slave      bus,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [1:0]           alu_op,
  input  logic [3:0]           alu_f
);
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state_q;
  logic [CW-1:0]        cnt_q;
  logic [NIB-1:0][3:0]  a_q;
  logic [NIB-1:0][3:0]  b_q;
  logic [NIB-1:0][3:0]  f_q;
  logic [1:0]           op_q;
  logic                 carry_q;
  logic                 cout_q;
  logic                 carry_nxt;
  logic                 last_nib;

  // Carry out of a nibble: a+b wrapped iff f < a; a+b+1 wrapped iff f <= a.
  function automatic logic nib_carry(input logic [1:0] op, input logic [3:0] f,
                                     input logic [3:0] a);
    if (op[1])
      return 1'b0;
    return op[0] ? (f <= a) : (f < a);
  endfunction

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (state_q == RUN) begin
      alu_a  = a_q[cnt_q];
      alu_b  = b_q[cnt_q];
      alu_op = op_q[1] ? op_q : {1'b0, carry_q};
    end
  end

  assign carry_nxt = nib_carry(alu_op, alu_f, alu_a);
  assign last_nib  = (cnt_q == CW'(NIB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            a_q     <= bus.cmd_a;
            b_q     <= bus.cmd_b;
            op_q    <= bus.cmd_op;
            cnt_q   <= '0;
            carry_q <= ~bus.cmd_op[1] & bus.cmd_op[0];
            state_q <= RUN;
          end
        end
        RUN: begin
          f_q[cnt_q] <= alu_f;
          carry_q    <= carry_nxt;
          if (last_nib) begin
            cout_q  <= carry_nxt;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (bus.res_ready)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_f     = f_q;
  assign bus.res_cout  = cout_q;
endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq: fixed vectors, backpressure, mid-run reset, and random
// operations checked against a W-bit arithmetic reference.
module tb_alu_nibble_seq;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] alu_a, alu_b, alu_f;
  logic [1:0] alu_op;

  always #5 clk = ~clk;

  alu_nibble_seq_if #(.NIB(NIB)) bus ();

  alu_nibble_seq #(.NIB(NIB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_op (alu_op),
    .alu_f  (alu_f)
  );

  // The 4-bit combinational ALU the sequencer drives.
  always_comb begin
    case (alu_op)
      2'b00:   alu_f = alu_a + alu_b;
      2'b01:   alu_f = alu_a + alu_b + 4'd1;
      2'b10:   alu_f = alu_a & alu_b;
      default: alu_f = alu_a | alu_b;
    endcase
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] f;
    logic         cout;
    logic [7:0]   ops;   // alu_op per nibble, nibble 0 in bits [1:0]
  } vec_t;

  vec_t vecs [6];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  // Present a command and hold it until the edge that accepts it.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !bus.cmd_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!bus.cmd_ready) check("accept_timeout", {31'b0, bus.cmd_ready}, 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Called in the first cycle after acceptance; returns the cycle index res_valid appeared in.
  task automatic collect(output logic [W-1:0] f, output logic cout, output int lat,
                         output logic [7:0] seq);
    int cyc;
    cyc = 1;
    seq = '0;
    while (!bus.res_valid && cyc < 40) begin
      if (cyc <= NIB) seq[2*(cyc-1) +: 2] = alu_op;
      @(posedge clk); #1;
      cyc++;
    end
    f    = bus.res_f;
    cout = bus.res_cout;
    lat  = cyc;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] f, hold_f;
    logic         cout;
    logic [W:0]   exp;
    logic [7:0]   seq;
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    int           lat;

    vecs[0] = '{16'h00FF, 16'h0001, 2'b00, 16'h0100, 1'b0, 8'b00_01_01_00};
    vecs[1] = '{16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 8'b01_01_01_00};
    vecs[2] = '{16'h1234, 16'h1111, 2'b01, 16'h2346, 1'b0, 8'b00_00_00_01};
    vecs[3] = '{16'hFFFF, 16'h0000, 2'b01, 16'h0000, 1'b1, 8'b01_01_01_01};
    vecs[4] = '{16'hF0F0, 16'hFF00, 2'b10, 16'hF000, 1'b0, 8'b10_10_10_10};
    vecs[5] = '{16'hF0F0, 16'hFF00, 2'b11, 16'hFFF0, 1'b0, 8'b11_11_11_11};

    rst_n         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_op    = '0;
    bus.res_ready = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    check("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
    check("rst_res_f",     {16'b0, bus.res_f}, 32'd0);
    check("rst_res_cout",  {31'b0, bus.res_cout}, 32'd0);
    check("rst_alu_in",    {22'b0, alu_op, alu_a, alu_b}, 32'd0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].op);
      collect(f, cout, lat, seq);
      check($sformatf("vec%0d_f", i),    {16'b0, f}, {16'b0, vecs[i].f});
      check($sformatf("vec%0d_cout", i), {31'b0, cout}, {31'b0, vecs[i].cout});
      check($sformatf("vec%0d_ops", i),  {24'b0, seq}, {24'b0, vecs[i].ops});
      check($sformatf("vec%0d_lat", i),  lat, NIB + 1);
      check($sformatf("vec%0d_done_alu_in", i), {22'b0, alu_op, alu_a, alu_b}, 32'd0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_idle", i), {30'b0, bus.res_valid, bus.cmd_ready}, 32'd1);
    end

    // Backpressure: result held while res_ready is low, second command refused.
    bus.res_ready = 1'b0;
    send(16'h0ABC, 16'h0123, 2'b00);
    collect(f, cout, lat, seq);
    check("bp_f",   {16'b0, f}, 32'h0BDF);
    check("bp_lat", lat, NIB + 1);
    hold_f        = bus.res_f;
    bus.cmd_a     = 16'h8000;
    bus.cmd_b     = 16'h8000;
    bus.cmd_op    = 2'b00;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_res_valid", {31'b0, bus.res_valid}, 32'd1);
      check("bp_res_f",     {16'b0, bus.res_f}, {16'b0, hold_f});
      check("bp_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {30'b0, bus.res_valid, bus.cmd_ready}, 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    collect(f, cout, lat, seq);
    check("bp2_f",    {16'b0, f}, 32'h0000);
    check("bp2_cout", {31'b0, cout}, 32'd1);
    check("bp2_lat",  lat, NIB + 1);
    @(posedge clk); #1;

    // Reset dropped while nibble 2 is in flight.
    send(16'hFFFF, 16'h0001, 2'b00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
    check("mid_rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
    check("mid_rst_alu_in",    {22'b0, alu_op, alu_a, alu_b}, 32'd0);
    check("mid_rst_res",       {15'b0, bus.res_cout, bus.res_f}, 32'd0);
    @(posedge clk); #1;
    check("mid_rst_hold_valid", {31'b0, bus.res_valid}, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h1234, 16'h4321, 2'b01);
    collect(f, cout, lat, seq);
    check("post_rst_f",    {16'b0, f}, 32'h5556);
    check("post_rst_cout", {31'b0, cout}, 32'd0);
    check("post_rst_lat",  lat, NIB + 1);
    @(posedge clk); #1;

    for (int i = 0; i < 1000; i++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rop = 2'($urandom_range(0, 3));
      send(ra, rb, rop);
      collect(f, cout, lat, seq);
      exp = ref_model(ra, rb, rop);
      if (i % 2 == 0) check("rand_lat", lat, NIB + 1);
      check($sformatf("rand%0d_f(op%0d %h,%h)", i, rop, ra, rb), {16'b0, f}, {16'b0, exp[W-1:0]});
      check($sformatf("rand%0d_cout", i), {31'b0, cout}, {31'b0, exp[W]});
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
